// File: rtl/hdmi_pkg.sv
// Shared TMDS constants and helpers for the HDMI output path.
package hdmi_pkg;

   localparam int WORD_BITS = 10;

   localparam logic [WORD_BITS-1:0] CTRL_00    = 10'b1101010100;
   localparam logic [WORD_BITS-1:0] CTRL_01    = 10'b0010101011;
   localparam logic [WORD_BITS-1:0] CTRL_10    = 10'b0101010100;
   localparam logic [WORD_BITS-1:0] CTRL_11    = 10'b1010101011;
   localparam logic [WORD_BITS-1:0] CLOCK_WORD = 10'b0000011111;

   function automatic int bits_per_cycle(input int ddr);
      return (ddr != 0) ? 2 : 1;
   endfunction

endpackage

// File: rtl/tmds_lane_shift.sv
// One TMDS channel: hold buffer, shift register and registered true/complement output pair.
module tmds_lane_shift
   import hdmi_pkg::*;
#(
   parameter int             WORD      = 10,
   parameter int             B         = 2,
   parameter logic           INV       = 1'b0,
   parameter logic [WORD-1:0] IDLE_WORD = CTRL_00
) (
   input  logic            clk_shift,
   input  logic            rst_n,
   input  logic            enable,
   input  logic            load,
   input  logic            hold_full,
   input  logic            wr_hold,
   input  logic [WORD-1:0] wr_data,
   output logic [B-1:0]    out_p,
   output logic [B-1:0]    out_n
);

   logic [WORD-1:0] hold_q,  hold_d;
   logic [WORD-1:0] shift_q, shift_d;
   logic [B-1:0]    out_p_q, out_p_d;
   logic [B-1:0]    out_n_q, out_n_d;

   always_comb begin
      hold_d  = wr_hold ? wr_data : hold_q;
      shift_d = shift_q >> B;
      if (!enable) begin
         shift_d = IDLE_WORD;
      end else if (load) begin
         // No bypass: an empty hold at load time means idle, even if a word arrives this edge.
         shift_d = hold_full ? hold_q : IDLE_WORD;
      end
      out_p_d = shift_q[B-1:0] ^ {B{INV}};
      out_n_d = ~out_p_d;
   end

   always_ff @(posedge clk_shift) begin
      if (!rst_n) begin
         hold_q  <= '0;
         shift_q <= IDLE_WORD;
         out_p_q <= '0;
         out_n_q <= '1;
      end else begin
         hold_q  <= hold_d;
         shift_q <= shift_d;
         out_p_q <= out_p_d;
         out_n_q <= out_n_d;
      end
   end

   assign out_p = out_p_q;
   assign out_n = out_n_q;

endmodule

// File: rtl/tmds_serializer_diff.sv
// Multi-channel TMDS serializer: word-phase counter, one-word buffer handshake, idle insertion.
module tmds_serializer_diff
   import hdmi_pkg::*;
#(
   parameter int              NCH       = 4,
   parameter int              DDR       = 1,
   parameter int              WORD      = 10,
   parameter logic [NCH-1:0]  INVERT    = {NCH{1'b0}},
   parameter logic [WORD-1:0] IDLE_WORD = CTRL_00
) (
   input  logic                               clk_shift,
   input  logic                               rst_n,
   input  logic                               enable,
   input  logic [NCH*WORD-1:0]                in_data,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic [NCH*bits_per_cycle(DDR)-1:0] out_p,
   output logic [NCH*bits_per_cycle(DDR)-1:0] out_n,
   output logic                               word_start,
   output logic                               underflow,
   input  logic                               underflow_clr
);

   localparam int B  = bits_per_cycle(DDR);
   localparam int S  = WORD / B;
   localparam int CW = (S > 1) ? $clog2(S) : 1;

   if ((WORD % B) != 0) begin : g_bad_word
      $error("WORD must be a multiple of the bits shifted per cycle");
   end

   logic [CW-1:0] cnt_q, cnt_d;
   logic          hold_full_q, hold_full_d;
   logic          word_start_q, word_start_d;
   logic          underflow_q, underflow_d;
   logic          load, xfer;

   assign load     = enable && (cnt_q == CW'(S - 1));
   assign in_ready = enable && rst_n && (!hold_full_q || load);
   assign xfer     = in_valid && in_ready;

   always_comb begin
      cnt_d        = cnt_q + CW'(1);
      hold_full_d  = hold_full_q;
      word_start_d = load;
      if (!enable || load) begin
         cnt_d = '0;
      end
      if (xfer) begin
         hold_full_d = 1'b1;
      end else if (load) begin
         hold_full_d = 1'b0;
      end
      // Idle insertion beats a simultaneous clear so no underflow event is ever lost.
      underflow_d = (load && !hold_full_q) || (underflow_q && !underflow_clr);
   end

   always_ff @(posedge clk_shift) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         hold_full_q  <= 1'b0;
         word_start_q <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         hold_full_q  <= hold_full_d;
         word_start_q <= word_start_d;
         underflow_q  <= underflow_d;
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_lane
      tmds_lane_shift #(
         .WORD      (WORD),
         .B         (B),
         .INV       (INVERT[c]),
         .IDLE_WORD (IDLE_WORD)
      ) u_lane (
         .clk_shift (clk_shift),
         .rst_n     (rst_n),
         .enable    (enable),
         .load      (load),
         .hold_full (hold_full_q),
         .wr_hold   (xfer),
         .wr_data   (in_data[c*WORD +: WORD]),
         .out_p     (out_p[c*B +: B]),
         .out_n     (out_n[c*B +: B])
      );
   end

   assign word_start = word_start_q;
   assign underflow  = underflow_q;

endmodule
